// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package pc_pkg;

    localparam int PC_W       = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BR,
        RD_J,
        RD_JR
    } redir_kind_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_target_calc.sv
// Combinational redirect target generation, jump_reg > jump > branch priority,
// and misaligned jump-register detection.
module pc_target_calc
    import pc_pkg::*;
(
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_base,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic [PC_W-1:0]   link_pc_plus4,
    input  logic              jump_reg,
    input  logic [PC_W-1:0]   jr_addr,
    output redir_kind_t       redir_kind,
    output logic [PC_W-1:0]   redir_target,
    output logic              addr_err
);

    logic [PC_W-1:0] br_disp;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;
    logic [PC_W-1:0] jr_target;

    // Word offset, sign-extended and scaled to bytes.
    generate
        for (genvar gi = 0; gi < PC_W; gi++) begin : g_disp
            if (gi < 2) begin : g_lo
                assign br_disp[gi] = 1'b0;
            end else if (gi < 18) begin : g_mid
                assign br_disp[gi] = branch_offset[gi-2];
            end else begin : g_sign
                assign br_disp[gi] = branch_offset[15];
            end
        end
    endgenerate

    assign br_target = branch_base + br_disp;
    assign j_target  = {link_pc_plus4[PC_W-1:28], jump_target, 2'b00};
    assign jr_target = word_align(jr_addr);
    assign addr_err  = jump_reg & (|jr_addr[1:0]);

    always_comb begin
        redir_kind   = RD_NONE;
        redir_target = '0;
        if (jump_reg) begin
            redir_kind   = RD_JR;
            redir_target = jr_target;
        end else if (jump) begin
            redir_kind   = RD_J;
            redir_target = j_target;
        end else if (branch_taken) begin
            redir_kind   = RD_BR;
            redir_target = br_target;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: PC register, imem handshake, stall hold and redirects.
// Define PC_DELAY_SLOT_EN to deliver the fetch that completes at/after a redirect (MIPS delay slot).
module pc_fetch_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_base,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        addr_err
);

    localparam logic [PC_W-1:0] RESET_PC = word_align(START_ADDR);
    localparam logic [PC_W-1:0] STEP     = PC_W'(WORD_BYTES);

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [PC_W-1:0]   last_pc_reg, last_pc_next;
    redir_kind_t       pend_kind_reg, pend_kind_next;
    logic [PC_W-1:0]   pend_target_reg, pend_target_next;

    redir_kind_t       calc_kind;
    logic [PC_W-1:0]   calc_target;
    logic              calc_err;
    logic              redir_now;
    logic              redirect_hit;
    logic              squash;
    logic [PC_W-1:0]   target_sel;
    logic              advance;
    logic              deliver;
    logic              req_c;

    // J-type upper bits come from the last instruction handed to decode.
    pc_target_calc u_target_calc (
        .branch_taken  (branch_taken),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .link_pc_plus4 (last_pc_reg + STEP),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .redir_kind    (calc_kind),
        .redir_target  (calc_target),
        .addr_err      (calc_err)
    );

    assign redir_now    = (calc_kind != RD_NONE);
    assign redirect_hit = redir_now | (pend_kind_reg != RD_NONE);
    assign target_sel   = redir_now ? calc_target : pend_target_reg;

`ifdef PC_DELAY_SLOT_EN
    // The completing fetch is the delay slot: always delivered, target follows it.
    assign squash = 1'b0;
`else
    assign squash = redirect_hit;
`endif

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        last_pc_next     = last_pc_reg;
        pend_kind_next   = pend_kind_reg;
        pend_target_next = pend_target_reg;
        req_c            = 1'b0;
        advance          = 1'b0;
        deliver          = 1'b0;

        case (state_reg)
            S_BOOT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    if (stall) begin
                        state_next = S_HOLD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    advance    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase

        deliver = advance & ~squash;

        // A redirect seen on an advancing cycle is consumed at once; otherwise it waits.
        if (advance) begin
            pc_next        = redirect_hit ? target_sel : pc_reg + STEP;
            pend_kind_next = RD_NONE;
            if (deliver) begin
                last_pc_next = pc_reg;
            end
        end else if (redir_now) begin
            pend_kind_next   = calc_kind;
            pend_target_next = calc_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_BOOT;
            pc_reg          <= RESET_PC;
            last_pc_reg     <= RESET_PC;
            pend_kind_reg   <= RD_NONE;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            last_pc_reg     <= last_pc_next;
            pend_kind_reg   <= pend_kind_next;
            pend_target_reg <= pend_target_next;
        end
    end

    assign imem_req       = req_c;
    assign imem_addr      = pc_reg;
    assign fetch_valid    = deliver & ~reset;
    assign fetch_pc       = fetch_valid ? pc_reg : last_pc_reg;
    assign fetch_pc_plus4 = fetch_pc + STEP;
    assign addr_err       = calc_err & ~reset;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer; expectations follow
// PC_DELAY_SLOT_EN when it is defined for the build.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] SA = 32'h0040_0000;
`ifdef PC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jump_reg, imem_ack;
    logic [31:0] branch_base, jr_addr;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic        imem_req, fetch_valid, addr_err;
    logic [31:0] imem_addr, fetch_pc, fetch_pc_plus4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.START_ADDR(SA)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_base    (branch_base),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_target    (jump_target),
        .jump_reg       (jump_reg),
        .jr_addr        (jr_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_pc_plus4 (fetch_pc_plus4),
        .addr_err       (addr_err)
    );

    typedef struct packed {
        logic        rst, stall, ack, br;
        logic [31:0] base;
        logic [15:0] off;
        logic        j;
        logic [25:0] jt;
        logic        jr;
        logic [31:0] jra;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] fpc;
        logic        err;
        logic        dvalid;
        logic [31:0] dfpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, stall, ack, br, input logic [31:0] base,
                                input logic [15:0] off, input logic j, input logic [25:0] jt,
                                input logic jr, input logic [31:0] jra, input logic req,
                                input logic [31:0] addr, input logic valid, input logic [31:0] fpc,
                                input logic err, input logic dvalid, input logic [31:0] dfpc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.ack = ack; v.br = br; v.base = base; v.off = off;
        v.j = j; v.jt = jt; v.jr = jr; v.jra = jra; v.req = req; v.addr = addr;
        v.valid = valid; v.fpc = fpc; v.err = err; v.dvalid = dvalid; v.dfpc = dfpc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        branch_taken = 1'b0; branch_base = '0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; jump_reg = 1'b0; jr_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; stall = v.stall; imem_ack = v.ack;
        branch_taken = v.br; branch_base = v.base; branch_offset = v.off;
        jump = v.j; jump_target = v.jt; jump_reg = v.jr; jr_addr = v.jra;
    endtask

    initial begin
        logic [31:0] exp_fpc;
        logic        exp_valid;
        bit          seen;

        idle_inputs();
        reset = 1'b1;

        // rst stall ack br base off j jt jr jra | req addr valid fpc err | ds_valid ds_fpc
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      0,SA,0,SA,0,                     0,SA));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA,1,SA,0,                     1,SA));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA+4,1,SA+4,0,                 1,SA+4));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,                      1,SA+8,0,SA+4,0,                 0,SA+4));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,                      0,SA+8,0,SA+4,0,                 0,SA+4));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,                      0,SA+8,0,SA+4,0,                 0,SA+4));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      0,SA+8,1,SA+8,0,                 1,SA+8));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA+12,1,SA+12,0,               1,SA+12));
        tbl.push_back(mk(0,0,1,1,32'h0040_0010,16'hFFFC,0,0,0,0,   1,SA+16,0,SA+12,0,               1,SA+16));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA,1,SA,0,                     1,SA));
        tbl.push_back(mk(0,0,0,1,32'h0040_0100,16'h0010,0,0,0,0,   1,SA+4,0,SA,0,                   0,SA));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      1,SA+4,0,SA,0,                   0,SA));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA+4,0,SA,0,                   1,SA+4));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h0040_0140,1,32'h0040_0140,0, 1,32'h0040_0140));
        tbl.push_back(mk(0,0,0,0,0,0,1,26'h100,0,0,                1,32'h0040_0144,0,32'h0040_0140,0, 0,32'h0040_0140));
        tbl.push_back(mk(0,0,0,1,32'h0040_0100,16'h0010,1,26'h100,1,32'h0000_1003, 1,32'h0040_0144,0,32'h0040_0140,1, 0,32'h0040_0140));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h0040_0144,0,32'h0040_0140,0, 1,32'h0040_0144));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h1000,1,32'h1000,0,         1,32'h1000));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,                      1,32'h1004,0,32'h1000,0,         0,32'h1000));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,1,32'h7FFF_FFFC,          0,32'h1004,0,32'h1000,0,         0,32'h1000));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      0,32'h1004,0,32'h1000,0,         1,32'h1004));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h7FFF_FFFC,1,32'h7FFF_FFFC,0, 1,32'h7FFF_FFFC));
        tbl.push_back(mk(0,0,1,0,0,0,1,26'h3FF_FFFF,0,0,           1,32'h8000_0000,0,32'h7FFF_FFFC,0, 1,32'h8000_0000));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h8FFF_FFFC,1,32'h8FFF_FFFC,0, 1,32'h8FFF_FFFC));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1,32'hFFFF_FFFC,          1,32'h9000_0000,0,32'h8FFF_FFFC,0, 1,32'h9000_0000));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0, 1,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,32'h0,1,32'h0,0,               1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      1,32'h4,0,32'h0,0,               0,32'h0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      1,32'h4,0,32'h0,0,               0,32'h0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,                      1,32'h4,0,32'h0,0,               0,32'h0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      0,SA,0,SA,0,                     0,SA));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,                      1,SA,0,SA,0,                     0,SA));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,0,                      1,SA,1,SA,0,                     1,SA));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #3;
            exp_valid = DS ? tbl[i].dvalid : tbl[i].valid;
            exp_fpc   = DS ? tbl[i].dfpc   : tbl[i].fpc;
            $display("vec %0d: req=%b addr=%h valid=%b fpc=%h err=%b", i, imem_req, imem_addr,
                     fetch_valid, fetch_pc, addr_err);
            check("imem_req",       i, 32'(imem_req),    32'(tbl[i].req));
            check("imem_addr",      i, imem_addr,        tbl[i].addr);
            check("fetch_valid",    i, 32'(fetch_valid), 32'(exp_valid));
            check("fetch_pc",       i, fetch_pc,         exp_fpc);
            check("fetch_pc_plus4", i, fetch_pc_plus4,   exp_fpc + 32'd4);
            check("addr_err",       i, 32'(addr_err),    32'(tbl[i].err));
            @(posedge clk);
            #1;
        end

        // Two redirects while a fetch is outstanding: the later one wins.
        idle_inputs();
        branch_taken = 1'b1; branch_base = SA; branch_offset = 16'h0004;
        #3;
        $display("seq a: req=%b addr=%h", imem_req, imem_addr);
        check("seq_a_addr", 100, imem_addr, SA + 32'd4);
        @(posedge clk); #1;
        idle_inputs();
        jump = 1'b1; jump_target = 26'h40;
        #3;
        $display("seq b: valid=%b", fetch_valid);
        check("seq_b_valid", 101, 32'(fetch_valid), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        imem_ack = 1'b1;
        #3;
        $display("seq c: valid=%b fpc=%h", fetch_valid, fetch_pc);
        check("seq_c_valid", 102, 32'(fetch_valid), DS ? 32'd1 : 32'd0);
        check("seq_c_fpc",   102, fetch_pc, DS ? SA + 32'd4 : SA);
        @(posedge clk); #1;
        idle_inputs();
        #3;
        $display("seq d: addr=%h", imem_addr);
        check("seq_d_addr", 103, imem_addr, 32'h0000_0100);

        // Reset during an outstanding fetch, then a bounded wait for the new request.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        imem_ack = 1'b1;
        #3;
        $display("seq e: req=%b addr=%h valid=%b", imem_req, imem_addr, fetch_valid);
        check("seq_e_req",   104, 32'(imem_req), 32'd0);
        check("seq_e_valid", 104, 32'(fetch_valid), 32'd0);
        imem_ack = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(posedge clk); #4;
            if (imem_req) seen = 1'b1;
        end
        check("seq_e_req_timeout", 105, 32'(seen), 32'd1);
        $display("seq f: req=%b addr=%h", imem_req, imem_addr);
        check("seq_f_addr", 105, imem_addr, SA);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
